hit_pattern_gen: RTL and testbench

- Synthesisable, parametrised hit-stimulus engine that drives the pixel-matrix `hit` bus of the sensor top in place of fixed bench-forced patterns.
- Generates framed hit patterns in four modes (all-on, walking pixel, pseudo-random pixel, row band), with programmable hold, gap and frame count.
- Sits on the fast system clock ahead of the matrix/readout path; used in simulation and on-chip self-test.

---
 rtl/hit_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_hit_pattern_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_pattern_gen.sv
// Framed hit-stimulus engine for the pixel matrix: ALL / WALK / RAND / ROW patterns
// with programmable hold, gap and frame count, all on the clk1 rising edge.
module hit_pattern_gen #(
  parameter int          N_PIX     = 4096,
  parameter int          ROW_W     = 64,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic             clk1,
  input  logic             sys_reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] hold_cyc,
  input  logic [CNT_W-1:0] gap_cyc,
  input  logic [CNT_W-1:0] n_frames,
  output logic [N_PIX-1:0] hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int          LOG_N     = $clog2(N_PIX);
  localparam int          N_ROWS    = N_PIX / ROW_W;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_PIX-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LOG_N-1:0]   idx_q, idx_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   nfr_q, nfr_d;

  logic               advance;
  logic               frame_last;
  logic [CNT_W-1:0]   fc_inc;
  logic [CNT_W-1:0]   hold_eff;
  logic [LOG_N-1:0]   idx_next;
  logic [31:0]        lfsr_next;

  // Galois right-shift step; the feedback taps keep a nonzero state nonzero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  function automatic logic [N_PIX-1:0] frame_pattern(input logic [1:0]       m,
                                                     input logic [LOG_N-1:0] idx,
                                                     input logic [31:0]      lf);
    logic [N_PIX-1:0] p;
    p = '0;
    case (m)
      2'd0: p = '1;
      2'd1: p[idx] = 1'b1;
      2'd2: p[lf[LOG_N-1:0]] = 1'b1;
      default: begin
        for (int i = 0; i < N_PIX; i++) begin
          p[i] = ((i / ROW_W) == (int'(idx) % N_ROWS));
        end
      end
    endcase
    return p;
  endfunction

  assign fc_inc     = frame_cnt_q + 1'b1;
  assign frame_last = (nfr_q != '0) && (fc_inc == nfr_q);
  assign hold_eff   = (hold_cyc == '0) ? CNT_W'(1) : hold_cyc;
  assign idx_next   = idx_q + 1'b1;
  assign lfsr_next  = lfsr_step(lfsr_q);

  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    frame_cnt_d = frame_cnt_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    nfr_d       = nfr_q;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d      = mode;
          hold_d      = hold_eff;
          gap_d       = gap_cyc;
          nfr_d       = n_frames;
          frame_cnt_d = '0;
          idx_d       = '0;
          lfsr_d      = LFSR_SEED;
          hit_d       = frame_pattern(mode, '0, LFSR_SEED);
          cnt_d       = hold_eff - 1'b1;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (stop) begin
          hit_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (gap_q != '0) begin
          hit_d   = '0;
          cnt_d   = gap_q - 1'b1;
          state_d = S_GAP;
        end else begin
          advance = 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame has completed: count it, then finish or load the next pattern.
    if (advance) begin
      frame_cnt_d = fc_inc;
      if (frame_last) begin
        hit_d   = '0;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_next;
        lfsr_d  = lfsr_next;
        hit_d   = frame_pattern(mode_q, idx_next, lfsr_next);
        cnt_d   = hold_q - 1'b1;
        state_d = S_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (sys_reset) begin
      state_q     <= S_IDLE;
      hit_q       <= '0;
      frame_cnt_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      frame_cnt_q <= frame_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Run configuration is always loaded at start before use, so it needs no reset.
  always_ff @(posedge clk1) begin
    mode_q <= mode_d;
    hold_q <= hold_d;
    gap_q  <= gap_d;
    nfr_q  <= nfr_d;
  end

  assign hit       = hit_q;
  assign busy      = (state_q == S_ACTIVE) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hit_pattern_gen.sv
// Directed and randomized runs of hit_pattern_gen (16 pixels, 4-pixel rows) against
// a frame-timeline model built from the pattern/timing rules.
module tb_hit_pattern_gen;
  localparam int          N_PIX = 16;
  localparam int          ROW_W = 4;
  localparam int          CNT_W = 16;
  localparam logic [31:0] SEED  = 32'hACE1_0001;

  logic             clk1 = 1'b0;
  logic             sys_reset, start, stop;
  logic [1:0]       mode;
  logic [CNT_W-1:0] hold_cyc, gap_cyc, n_frames;
  logic [N_PIX-1:0] hit;
  logic             busy, done;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [N_PIX-1:0] q_hit[$];
  logic             q_busy[$];
  logic             q_done[$];
  int               q_fc[$];

  hit_pattern_gen #(.N_PIX(N_PIX), .ROW_W(ROW_W), .CNT_W(CNT_W), .LFSR_SEED(SEED)) dut (
    .clk1(clk1), .sys_reset(sys_reset), .start(start), .stop(stop), .mode(mode),
    .hold_cyc(hold_cyc), .gap_cyc(gap_cyc), .n_frames(n_frames),
    .hit(hit), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk1 = ~clk1;

  // LFSR state after k frame loads, polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_after(input int k);
    logic [31:0] s;
    s = SEED;
    for (int j = 0; j < k; j++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  function automatic logic [N_PIX-1:0] exp_pat(input int m, input int k);
    logic [N_PIX-1:0] one;
    logic [N_PIX-1:0] rowm;
    logic [31:0]      s;
    one  = 1;
    rowm = N_PIX'((1 << ROW_W) - 1);
    case (m)
      0: return '1;
      1: return one << (k % N_PIX);
      2: begin
        s = lfsr_after(k);
        return one << (s % N_PIX);
      end
      default: return rowm << (ROW_W * (k % (N_PIX / ROW_W)));
    endcase
  endfunction

  // Expected per-cycle outputs, starting with the sample right after the start edge.
  task automatic build(input int m, input int h, input int g, input int n, input int limit);
    int he;
    int k;
    q_hit.delete(); q_busy.delete(); q_done.delete(); q_fc.delete();
    he = (h == 0) ? 1 : h;
    k  = 0;
    forever begin
      if (n != 0 && k == n) begin
        q_hit.push_back('0); q_busy.push_back(1'b0); q_done.push_back(1'b1); q_fc.push_back(n);
        q_hit.push_back('0); q_busy.push_back(1'b0); q_done.push_back(1'b0); q_fc.push_back(n);
        break;
      end
      if (q_hit.size() >= limit) break;
      for (int j = 0; j < he; j++) begin
        q_hit.push_back(exp_pat(m, k)); q_busy.push_back(1'b1); q_done.push_back(1'b0); q_fc.push_back(k);
      end
      for (int j = 0; j < g; j++) begin
        q_hit.push_back('0); q_busy.push_back(1'b1); q_done.push_back(1'b0); q_fc.push_back(k);
      end
      k++;
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input int i);
    chk($sformatf("%s[%0d].hit", tag, i), 32'(hit), 32'(q_hit[i]));
    chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(q_busy[i]));
    chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(q_done[i]));
    chk($sformatf("%s[%0d].frame_cnt", tag, i), 32'(frame_cnt), 32'(q_fc[i]));
  endtask

  task automatic chk_idle(input string tag, input int fc);
    chk({tag, ".hit"}, 32'(hit), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
  endtask

  task automatic apply_cfg(input int m, input int h, input int g, input int n);
    mode = 2'(m); hold_cyc = CNT_W'(h); gap_cyc = CNT_W'(g); n_frames = CNT_W'(n);
  endtask

  // Full run; configuration inputs are scrambled mid-run and must be ignored.
  task automatic run(input int m, input int h, input int g, input int n, input string tag);
    build(m, h, g, n, 1000);
    apply_cfg(m, h, g, n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < q_hit.size(); i++) begin
      chk_sample(tag, i);
      if (m == 2 && q_hit[i] != '0)
        chk($sformatf("%s[%0d].onehot", tag, i), 32'($countones(hit)), 32'd1);
      mode = 2'($urandom); hold_cyc = CNT_W'($urandom);
      gap_cyc = CNT_W'($urandom); n_frames = CNT_W'($urandom);
      tick();
    end
  endtask

  initial begin
    sys_reset = 1'b1; start = 1'b0; stop = 1'b0;
    apply_cfg(0, 0, 0, 0);
    tick();
    tick();
    chk_idle("reset", 0);
    sys_reset = 1'b0;
    tick();
    chk_idle("post_reset", 0);

    // start together with stop in IDLE is refused
    apply_cfg(1, 2, 0, 3);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_idle("start_stop_idle", 0);
    tick();
    chk_idle("start_stop_idle2", 0);

    run(0, 3, 2, 2, "all");
    run(1, 1, 0, 18, "walk");
    run(2, 0, 0, 8, "rand_a");
    tick();
    run(2, 0, 0, 8, "rand_b");
    run(3, 2, 0, 5, "row");

    // continuous WALK: start mid-run is ignored, stop aborts without done
    build(1, 2, 1, 0, 7);
    apply_cfg(1, 2, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_sample("stop_run", i);
      start = (i == 3);
      stop  = (i == 6);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    chk_idle("stop_edge", 2);
    tick();
    chk_idle("stop_after", 2);

    // reset during GAP clears the run, even with start asserted alongside
    build(2, 2, 3, 4, 1000);
    apply_cfg(2, 2, 3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_sample("rst_run", i);
      sys_reset = (i == 2);
      start     = (i == 2);
      tick();
    end
    sys_reset = 1'b0; start = 1'b0;
    chk_idle("rst_edge", 0);
    tick();
    chk_idle("rst_after", 0);
    run(2, 2, 3, 4, "rand_replay");

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), $sformatf("rnd%0d", r));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
